imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single-ported, synchronous-read instruction memory between the CPU fetch stage and the program loader/debug port. Each cycle it grants at most one requester and drives the memory port. It returns read data with a fixed one-cycle latency. Loader writes take priority, but a bounded-streak rule keeps fetch from starving.

## Interface
Parameters:
- WORDS, 256: memory depth in 32-bit words; power of two.
- AW, 8: word-index width, equal to clog2(WORDS).
- LOCK_MAX, 4: maximum consecutive contended loader grants before one fetch grant is forced; range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  fetch read request; held until fetch_gnt.
- fetch_addr  in  32  byte address of the fetch.
- fetch_gnt  out  1  fetch access issued this cycle.
- fetch_rvalid  out  1  fetch_rdata valid; asserted the cycle after fetch_gnt.
- fetch_rdata  out  32  returned instruction word.
- ld_req  in  1  loader request; held until ld_gnt.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_gnt  out  1  loader access issued this cycle.
- ld_rvalid  out  1  loader read data valid; the cycle after a read grant only.
- ld_rdata  out  32  loader read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  word index.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data; valid the cycle after mem_en with mem_we=0.
- cpu_stall  out  1  fetch_req & ~fetch_gnt.

## Operation
- Word index is addr[AW+1:2]. Bits [1:0] are ignored, and bits above AW+1 are dropped, so accesses wrap modulo WORDS.
- Grant decision is combinational in the request cycle:
  - With reset high, no grants are issued.
  - If only one requester is active, that requester is granted.
  - If both are active and streak < LOCK_MAX, the loader is granted.
  - If both are active and streak == LOCK_MAX, fetch is granted.
- streak register, 4 bits:
  - +1, saturating at LOCK_MAX, on a loader grant while fetch_req=1.
  - Cleared to 0 on any fetch grant, and on any cycle with fetch_req=0.
- Memory port:
  - mem_en = fetch_gnt | ld_gnt.
  - mem_we = ld_gnt & ld_we.
  - mem_addr and mem_wdata come from the granted requester.
  - When idle, mem_addr and mem_wdata are 0.
- Read return uses a one-bit owner tag plus a valid flag, both registered at grant:
  - The next cycle raises exactly one of fetch_rvalid or ld_rvalid.
  - The corresponding rdata equals mem_rdata. The non-owner rdata is 0.
- Loader writes complete on the grant cycle and produce no rvalid.
- Reset values: fetch_gnt, ld_gnt, fetch_rvalid, ld_rvalid, mem_en, mem_we, cpu_stall = 0; rdata = 0; streak = 0; owner tag cleared.

## Timing
- Grant latency is 0 cycles from request; read latency is 1 cycle from grant.
- Throughput is one access per cycle. Back-to-back grants to either requester, or alternating between them, are legal. A new grant in cycle T+1 coexists with the rvalid for the cycle-T grant.
- Requester addresses and data are sampled only in the grant cycle. A requester may change them after the grant.
- Reset asserted in cycle T+1, after a read grant in T: rvalid in T+1 is still driven from the registered flag, and the flag is cleared at the end of T+1. Reset asserted in T: no grant, and no rvalid in T+1.
- While reset=1, cpu_stall = 0 regardless of fetch_req.
- Simultaneous requests with streak == LOCK_MAX: fetch is granted, streak becomes 0, and the loader is granted next cycle if it is still requesting.

## Test plan
- Fetch only: fetch_req at addr 0x00, 0x04, 0x3FC on consecutive cycles.
  - Required: fetch_gnt each cycle; mem_addr 0, 1, 255.
  - Required: fetch_rvalid one cycle later with memory contents; cpu_stall=0.
- Wrap: fetch_addr 0x400 and 0x403 with WORDS=256.
  - Required: mem_addr=0 both times; low two bits ignored.
- Loader write then fetch readback:
  - ld_we=1, addr 0x10, data 0xDEADBEEF. Required: mem_we=1, mem_addr=4, no ld_rvalid.
  - Fetch of 0x10 next cycle. Required: fetch_rdata=0xDEADBEEF one cycle after its grant.
- Contention, LOCK_MAX=4, both requesting continuously:
  - Required grant pattern: L, L, L, L, F, L, L, L, L, F.
  - Required: cpu_stall=1 exactly on the loader-grant cycles.
- Interleaved reads: loader read in T, fetch read in T+1.
  - Required: ld_rvalid only in T+1 and fetch_rvalid only in T+2, each with the correct word; the non-owner rdata is 0.
- Reset mid-operation:
  - Reset in the cycle after a read grant: rvalid still high that cycle, then streak=0 and all outputs 0.
  - Requests held during reset: not granted until the cycle after reset deasserts.

Source files
------------

// File: rtl/imem_arbiter.sv
// Arbiter sharing a single-ported, synchronous-read instruction memory between
// CPU fetch and the loader/debug port, with a bounded loader streak under contention.
module imem_arbiter #(
   parameter int unsigned WORDS    = 256,
   parameter int unsigned AW       = 8,
   parameter int unsigned LOCK_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fetch_req,
   input  logic [31:0]   fetch_addr,
   output logic          fetch_gnt,
   output logic          fetch_rvalid,
   output logic [31:0]   fetch_rdata,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [31:0]   ld_addr,
   input  logic [31:0]   ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [31:0]   ld_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          cpu_stall
);

   typedef enum logic {
      OWN_LD    = 1'b0,
      OWN_FETCH = 1'b1
   } owner_t;

   localparam logic [3:0]    LOCK_LIM = 4'(LOCK_MAX);
   localparam logic [AW-1:0] IDX_MASK = AW'(WORDS - 1);

   logic [3:0]    streak;
   logic [3:0]    streak_nxt;
   logic          streak_full;
   logic          grant_fetch;
   logic          grant_ld;
   logic          rd_valid;
   owner_t        rd_owner;
   logic [AW-1:0] fetch_idx;
   logic [AW-1:0] ld_idx;
   logic          unused_addr_bits;

   // Byte offset and bits above the array are dropped so accesses wrap.
   assign fetch_idx = fetch_addr[AW+1:2] & IDX_MASK;
   assign ld_idx    = ld_addr[AW+1:2] & IDX_MASK;
   assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0],
                               ld_addr[31:AW+2], ld_addr[1:0]};

   assign streak_full = (streak == LOCK_LIM);

   always_comb begin
      grant_fetch = 1'b0;
      grant_ld    = 1'b0;
      if (!reset) begin
         if (fetch_req && (!ld_req || streak_full)) begin
            grant_fetch = 1'b1;
         end else if (ld_req) begin
            grant_ld = 1'b1;
         end
      end
   end

   always_comb begin
      streak_nxt = streak;
      if (!fetch_req || grant_fetch) begin
         streak_nxt = '0;
      end else if (grant_ld && !streak_full) begin
         streak_nxt = streak + 4'd1;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_fetch) begin
         mem_addr = fetch_idx;
      end else if (grant_ld) begin
         mem_addr  = ld_idx;
         mem_wdata = ld_wdata;
      end
   end

   assign fetch_gnt = grant_fetch;
   assign ld_gnt    = grant_ld;
   assign mem_en    = grant_fetch | grant_ld;
   assign mem_we    = grant_ld & ld_we;
   assign cpu_stall = fetch_req & ~grant_fetch & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         streak   <= '0;
         rd_valid <= 1'b0;
         rd_owner <= OWN_LD;
      end else begin
         streak   <= streak_nxt;
         rd_valid <= grant_fetch | (grant_ld & ~ld_we);
         rd_owner <= grant_fetch ? OWN_FETCH : OWN_LD;
      end
   end

   assign fetch_rvalid = rd_valid & (rd_owner == OWN_FETCH);
   assign ld_rvalid    = rd_valid & (rd_owner == OWN_LD);
   assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
   assign ld_rdata     = ld_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural synchronous-read memory;
// unwritten words read back as 0xA500_0000 | index.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_gnt;
   logic        fetch_rvalid;
   logic [31:0] fetch_rdata;
   logic        ld_req;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_gnt;
   logic        ld_rvalid;
   logic [31:0] ld_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        cpu_stall;

   int unsigned tests  = 0;
   int unsigned failed = 0;

   logic [31:0]  mem_arr [256];
   logic [255:0] written = '0;

   always #5 clk = ~clk;

   imem_arbiter #(.WORDS(256), .AW(8), .LOCK_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem_arr[mem_addr]  <= mem_wdata;
            written[mem_addr]  <= 1'b1;
         end else begin
            mem_rdata <= written[mem_addr] ? mem_arr[mem_addr]
                                           : (32'hA500_0000 | {24'h0, mem_addr});
         end
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the falling edge; checks run 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;

      // Reset with both requesters active
      next_cycle();
      fetch_req = 1'b1; ld_req = 1'b1;
      #1;
      chk1("rst_fetch_gnt", fetch_gnt, 1'b0);
      chk1("rst_ld_gnt", ld_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_stall", cpu_stall, 1'b0);
      chk1("rst_fetch_rvalid", fetch_rvalid, 1'b0);
      chk1("rst_ld_rvalid", ld_rvalid, 1'b0);
      chk32("rst_fetch_rdata", fetch_rdata, 32'h0);
      chk32("rst_mem_addr", {24'h0, mem_addr}, 32'h0);

      // Fetch only, including wrap and ignored low bits
      next_cycle();
      reset = 1'b0; ld_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
      #1;
      chk1("f0_gnt", fetch_gnt, 1'b1);
      chk1("f0_mem_en", mem_en, 1'b1);
      chk1("f0_mem_we", mem_we, 1'b0);
      chk1("f0_stall", cpu_stall, 1'b0);
      chk32("f0_addr", {24'h0, mem_addr}, 32'd0);

      next_cycle();
      fetch_addr = 32'h4;
      #1;
      chk1("f1_gnt", fetch_gnt, 1'b1);
      chk32("f1_addr", {24'h0, mem_addr}, 32'd1);
      chk1("f0_rvalid", fetch_rvalid, 1'b1);
      chk32("f0_rdata", fetch_rdata, 32'hA500_0000);
      chk1("f0_ld_rvalid", ld_rvalid, 1'b0);
      chk32("f0_ld_rdata", ld_rdata, 32'h0);

      next_cycle();
      fetch_addr = 32'h3FC;
      #1;
      chk32("f2_addr", {24'h0, mem_addr}, 32'd255);
      chk32("f1_rdata", fetch_rdata, 32'hA500_0001);

      next_cycle();
      fetch_addr = 32'h400;
      #1;
      chk32("wrap400_addr", {24'h0, mem_addr}, 32'd0);
      chk32("f2_rdata", fetch_rdata, 32'hA500_00FF);

      next_cycle();
      fetch_addr = 32'h403;
      #1;
      chk32("wrap403_addr", {24'h0, mem_addr}, 32'd0);
      chk32("wrap400_rdata", fetch_rdata, 32'hA500_0000);

      // Loader write then fetch readback
      next_cycle();
      fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b1;
      ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
      #1;
      chk1("wr_ld_gnt", ld_gnt, 1'b1);
      chk1("wr_fetch_gnt", fetch_gnt, 1'b0);
      chk1("wr_mem_we", mem_we, 1'b1);
      chk32("wr_addr", {24'h0, mem_addr}, 32'd4);
      chk32("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk32("wrap403_rdata", fetch_rdata, 32'hA500_0000);

      next_cycle();
      ld_req = 1'b0; ld_we = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h10;
      #1;
      chk1("wr_no_ld_rvalid", ld_rvalid, 1'b0);
      chk1("wr_no_fetch_rvalid", fetch_rvalid, 1'b0);
      chk1("rb_gnt", fetch_gnt, 1'b1);
      chk32("rb_addr", {24'h0, mem_addr}, 32'd4);

      next_cycle();
      fetch_req = 1'b0;
      #1;
      chk1("rb_rvalid", fetch_rvalid, 1'b1);
      chk32("rb_rdata", fetch_rdata, 32'hDEAD_BEEF);
      chk1("idle_mem_en", mem_en, 1'b0);
      chk32("idle_mem_addr", {24'h0, mem_addr}, 32'h0);
      chk32("idle_mem_wdata", mem_wdata, 32'h0);

      // Contention: L L L L F L L L L F
      fetch_addr = 32'h20;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         fetch_req = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
         ld_addr = 32'h40 + 32'(i) * 32'd4; ld_wdata = 32'h1111_0000 + 32'(i);
         #1;
         chk1("cont_fetch_gnt", fetch_gnt, (i == 4) || (i == 9));
         chk1("cont_ld_gnt", ld_gnt, !((i == 4) || (i == 9)));
         chk1("cont_stall", cpu_stall, !((i == 4) || (i == 9)));
         chk1("cont_fetch_rvalid", fetch_rvalid, (i == 5));
      end

      // Interleaved reads: loader read, then fetch read
      next_cycle();
      fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h08;
      #1;
      chk1("il_ld_gnt", ld_gnt, 1'b1);
      chk1("il_ld_mem_we", mem_we, 1'b0);
      chk1("cont_last_rvalid", fetch_rvalid, 1'b1);
      chk32("cont_last_rdata", fetch_rdata, 32'hA500_0008);

      next_cycle();
      ld_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0C;
      #1;
      chk1("il_fetch_gnt", fetch_gnt, 1'b1);
      chk1("il_ld_rvalid", ld_rvalid, 1'b1);
      chk32("il_ld_rdata", ld_rdata, 32'hA500_0002);
      chk1("il_fetch_rvalid_early", fetch_rvalid, 1'b0);
      chk32("il_fetch_rdata_early", fetch_rdata, 32'h0);

      next_cycle();
      fetch_req = 1'b0;
      #1;
      chk1("il_fetch_rvalid", fetch_rvalid, 1'b1);
      chk32("il_fetch_rdata", fetch_rdata, 32'hA500_0003);
      chk1("il_ld_rvalid_late", ld_rvalid, 1'b0);
      chk32("il_ld_rdata_late", ld_rdata, 32'h0);

      // Reset the cycle after a loader read grant, requests held throughout
      next_cycle();
      fetch_req = 1'b1; fetch_addr = 32'h14; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h18;
      #1;
      chk1("pre_rst_ld_gnt", ld_gnt, 1'b1);
      chk1("pre_rst_stall", cpu_stall, 1'b1);

      next_cycle();
      reset = 1'b1;
      #1;
      chk1("mid_rst_ld_rvalid", ld_rvalid, 1'b1);
      chk32("mid_rst_ld_rdata", ld_rdata, 32'hA500_0006);
      chk1("mid_rst_fetch_gnt", fetch_gnt, 1'b0);
      chk1("mid_rst_ld_gnt", ld_gnt, 1'b0);
      chk1("mid_rst_stall", cpu_stall, 1'b0);
      chk1("mid_rst_mem_en", mem_en, 1'b0);

      next_cycle();
      #1;
      chk1("rst2_ld_rvalid", ld_rvalid, 1'b0);
      chk32("rst2_ld_rdata", ld_rdata, 32'h0);
      chk1("rst2_fetch_rvalid", fetch_rvalid, 1'b0);
      chk1("rst2_ld_gnt", ld_gnt, 1'b0);

      // After reset the streak restarts at 0: four loader grants, then fetch
      for (int j = 0; j < 5; j++) begin
         next_cycle();
         reset = 1'b0;
         #1;
         chk1("post_rst_fetch_gnt", fetch_gnt, (j == 4));
         chk1("post_rst_ld_gnt", ld_gnt, (j != 4));
         chk1("post_rst_ld_rvalid", ld_rvalid, (j >= 1));
      end

      next_cycle();
      fetch_req = 1'b0; ld_req = 1'b0;
      #1;
      chk1("final_fetch_rvalid", fetch_rvalid, 1'b1);
      chk32("final_fetch_rdata", fetch_rdata, 32'hA500_0005);
      chk1("final_mem_en", mem_en, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
